alu_exec_stage: RTL and testbench
=================================

Name: alu_exec_stage

Overview:
- Execute stage directly downstream of RegFile in the multicycle datapath.
- Latches the operands read on Bus_A/Bus_B and performs the ALU operation; MUL runs as an iterative 32-cycle shift-add.
- Feeds the result back to RegFile through RW, Bus_W and reg_write in a single write-back cycle.
- Issue is one instruction at a time: start/ready handshake, done pulse.

Parameters:
- DATA_W, 32, operand/result width.
- REG_AW, 5, register address width.
- MUL_CYCLES, 32, multiplier iterations; equals DATA_W.

Ports:
- clk  in  1  rising-edge clock.
- rst  in  1  synchronous active-high reset.
- start  in  1  issue request; sampled only when ready=1.
- ready  out  1  high in IDLE.
- op  in  4  opcode.
- Bus_A  in  DATA_W  operand A from RegFile.
- Bus_B  in  DATA_W  operand B from RegFile.
- use_imm  in  1  replaces B with sign-extended imm.
- imm  in  16  immediate.
- rd  in  REG_AW  destination register.
- RW  out  REG_AW  write address to RegFile.
- Bus_W  out  DATA_W  write data to RegFile.
- reg_write  out  1  write enable to RegFile; one-cycle pulse.
- done  out  1  one-cycle completion pulse.
- zero  out  1  result==0, valid with done.
- err  out  1  one-cycle illegal-opcode pulse.

Behaviour:
- Reset: state IDLE. ready=1. RW=0, Bus_W=0, reg_write=0, done=0, zero=0, err=0. Internal A, B, op, rd and product registers cleared.
- Acceptance (cycle 0): start=1 while in IDLE.
  - Latches A=Bus_A.
  - Latches B = use_imm ? {{16{imm[15]}},imm} : Bus_B.
  - Latches op and rd.
  - Next state EXEC. Inputs are ignored until the stage returns to IDLE.
- Opcodes:
  - 0 ADD, 1 SUB, 2 AND, 3 OR, 4 XOR.
  - 5 SLL, 6 SRL, 7 SRA; shift amount is B[4:0].
  - 8 SLT (signed), 9 SLTU; result is 0 or 1.
  - 10 MUL; result is the low DATA_W bits of the unsigned product.
  - 11-15 illegal.
- Arithmetic: modulo 2^DATA_W; overflow and carry are discarded.
- EXEC (cycle 1):
  - Non-MUL legal op: result register loaded; next state WB.
  - MUL: counter loaded with MUL_CYCLES, accumulator cleared; next state MUL.
  - Illegal op: result=0; next state WB with the illegal flag set.
- MUL (cycles 2..33): each cycle, if B[0], accumulator += A; then A<<=1, B>>=1, counter decrements. Counter reaching 0 moves to WB.
- WB (ALU ops cycle 2, MUL cycle 34):
  - done=1; RW=rd; Bus_W=result; zero=(result==0).
  - reg_write=1 only if rd!=0 and op is legal.
  - Illegal op: err=1, reg_write=0.
  - Next state IDLE; ready is back to 1 in the following cycle.
- Between write-backs, RW and Bus_W hold their last values. reg_write, done and err are 0 outside WB.
- rd=0: done pulses; reg_write is suppressed.
- start held high continuously: a new issue is accepted every time the stage is in IDLE. Back-to-back ALU issue therefore occurs every 3 cycles.
- rst in any state (including mid-MUL): IDLE next cycle, no write-back, all outputs return to their reset values.
- Latency: ALU ops have done 2 cycles after acceptance; MUL 34 cycles after acceptance.

Optional Feature:
- Macro MUL_EN.
- Defined: opcode 10 executes MUL as described above.
- Undefined: no multiplier logic is built and opcode 10 is treated as illegal (err pulse, no reg_write, done after 2 cycles).

Decomposition:
- Package alu_pkg: opcode constants OP_ADD..OP_MUL, state enum {IDLE, EXEC, MUL, WB}, DATA_W and REG_AW defaults.
- Sub-module seq_mul holds the shift-add multiplier: A/B shift registers, accumulator and counter. It has a start/done interface and is instantiated only under MUL_EN.

Test Plan:
- ADD: A=5, B=7, rd=3 -> cycle 2: reg_write=1, RW=3, Bus_W=12, done=1, zero=0; ready returns to 1 in cycle 3.
- SUB with immediate: A=10, use_imm=1, imm=0xFFFF, rd=4 -> Bus_W=11.
- SUB to zero: A=B=9 -> Bus_W=0, zero=1.
- SRA: A=0x80000000, B=4 -> Bus_W=0xF8000000.
- SLT: A=0xFFFFFFFF, B=1 -> Bus_W=1. SLTU with the same operands -> Bus_W=0.
- MUL (MUL_EN defined): A=0x10001, B=0x10001, rd=7 -> done exactly 34 cycles after acceptance, Bus_W=0x00020001. start pulsed during the busy period is ignored.
- Illegal op 12, rd=5 -> cycle 2: err=1, done=1, reg_write=0. Without MUL_EN, op 10 gives the same response.
- rd=0 ADD -> done=1, reg_write=0.
- rst asserted at cycle 15 of a MUL -> state IDLE and all outputs 0 next cycle; no reg_write pulse ever appears for that MUL.

Source files
------------

// File: rtl/alu_pkg.sv
// Shared constants and types for the ALU execute stage.
// Opcode 10 (MUL) is only legal when the design is built with MUL_EN.
package alu_pkg;

  localparam int DEF_DATA_W = 32;
  localparam int DEF_REG_AW = 5;

  localparam logic [3:0] OP_ADD  = 4'd0;
  localparam logic [3:0] OP_SUB  = 4'd1;
  localparam logic [3:0] OP_AND  = 4'd2;
  localparam logic [3:0] OP_OR   = 4'd3;
  localparam logic [3:0] OP_XOR  = 4'd4;
  localparam logic [3:0] OP_SLL  = 4'd5;
  localparam logic [3:0] OP_SRL  = 4'd6;
  localparam logic [3:0] OP_SRA  = 4'd7;
  localparam logic [3:0] OP_SLT  = 4'd8;
  localparam logic [3:0] OP_SLTU = 4'd9;
  localparam logic [3:0] OP_MUL  = 4'd10;

  typedef enum logic [1:0] {
    IDLE,
    EXEC,
    MUL,
    WB
  } state_t;

  function automatic logic is_legal_op(input logic [3:0] op);
    logic legal;
    legal = (op <= OP_SLTU);
`ifdef MUL_EN
    legal = legal || (op == OP_MUL);
`endif
    return legal;
  endfunction

endpackage

// File: rtl/alu_exec_stage_seq_mul.sv
// Iterative shift-add multiplier: one partial product per cycle, low DATA_W bits kept.
// Instantiated by alu_exec_stage only when MUL_EN is defined.
module seq_mul #(
  parameter int DATA_W     = 32,
  parameter int MUL_CYCLES = 32
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              i_start,
  input  logic [DATA_W-1:0] i_a,
  input  logic [DATA_W-1:0] i_b,
  output logic              o_done,
  output logic [DATA_W-1:0] o_product
);

  localparam int CNT_W = $clog2(MUL_CYCLES + 1);

  logic [DATA_W-1:0] r_a;
  logic [DATA_W-1:0] r_b;
  logic [DATA_W-1:0] r_acc;
  logic [CNT_W-1:0]  r_cnt;
  logic [DATA_W-1:0] w_acc_next;

  assign w_acc_next = r_acc + (r_b[0] ? r_a : '0);

  // NOTE: sequential state uses <= so every register samples pre-edge values.
  always_ff @(posedge clk) begin
    // NOTE: the datapath registers are reset too, so an aborted product leaves nothing behind.
    if (rst) begin
      r_a   <= '0;
      r_b   <= '0;
      r_acc <= '0;
      r_cnt <= '0;
    end else if (i_start) begin
      r_a   <= i_a;
      r_b   <= i_b;
      r_acc <= '0;
      r_cnt <= CNT_W'(MUL_CYCLES);
    end else if (r_cnt != '0) begin
      r_acc <= w_acc_next;
      r_a   <= r_a << 1;
      r_b   <= r_b >> 1;
      r_cnt <= r_cnt - CNT_W'(1);
    end
  end

  // Final iteration: the product is the accumulator after this cycle's add.
  assign o_done    = (r_cnt == CNT_W'(1));
  assign o_product = w_acc_next;

endmodule

// File: rtl/alu_exec_stage.sv
// Execute stage: latch operands, run the ALU op (or iterative MUL), write back once.
// Build option MUL_EN adds the shift-add multiplier; without it opcode 10 is illegal.
module alu_exec_stage
  import alu_pkg::*;
#(
  parameter int DATA_W     = DEF_DATA_W,
  parameter int REG_AW     = DEF_REG_AW,
  parameter int MUL_CYCLES = DATA_W
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  output logic              ready,
  input  logic [3:0]        op,
  input  logic [DATA_W-1:0] Bus_A,
  input  logic [DATA_W-1:0] Bus_B,
  input  logic              use_imm,
  input  logic [15:0]       imm,
  input  logic [REG_AW-1:0] rd,
  output logic [REG_AW-1:0] RW,
  output logic [DATA_W-1:0] Bus_W,
  output logic              reg_write,
  output logic              done,
  output logic              zero,
  output logic              err
);

  if (MUL_CYCLES != DATA_W) begin : g_bad_cfg
    $error("alu_exec_stage: MUL_CYCLES must equal DATA_W");
  end

  state_t            r_state;
  state_t            w_state_next;
  logic [DATA_W-1:0] r_a;
  logic [DATA_W-1:0] r_b;
  logic [3:0]        r_op;
  logic [REG_AW-1:0] r_rd;
  logic [REG_AW-1:0] r_rw;
  logic [DATA_W-1:0] r_bus_w;
  logic              r_reg_write;
  logic              r_done;
  logic              r_zero;
  logic              r_err;

  logic              w_accept;
  logic              w_legal;
  logic [4:0]        w_shamt;
  logic [DATA_W-1:0] w_alu;
  logic              w_mul_start;
  logic              w_mul_done;
  logic              w_wb_load;
  logic [DATA_W-1:0] w_wb_data;

  assign ready    = (r_state == IDLE);
  assign w_accept = ready && start;
  assign w_legal  = is_legal_op(r_op);
  assign w_shamt  = r_b[4:0];

`ifdef MUL_EN
  logic [DATA_W-1:0] w_mul_product;

  assign w_mul_start = (r_state == EXEC) && (r_op == OP_MUL);

  seq_mul #(
    .DATA_W     (DATA_W),
    .MUL_CYCLES (MUL_CYCLES)
  ) u_seq_mul (
    .clk       (clk),
    .rst       (rst),
    .i_start   (w_mul_start),
    .i_a       (r_a),
    .i_b       (r_b),
    .o_done    (w_mul_done),
    .o_product (w_mul_product)
  );

  assign w_wb_data = (r_state == MUL) ? w_mul_product : w_alu;
`else
  assign w_mul_start = 1'b0;
  assign w_mul_done  = 1'b0;
  assign w_wb_data   = w_alu;
`endif

  assign w_wb_load = ((r_state == EXEC) && !w_mul_start) ||
                     ((r_state == MUL) && w_mul_done);

  // NOTE: every always_comb output gets a default first, so no path can infer a latch.
  always_comb begin
    w_alu = '0;
    case (r_op)
      OP_ADD:  w_alu = r_a + r_b;
      OP_SUB:  w_alu = r_a - r_b;
      OP_AND:  w_alu = r_a & r_b;
      OP_OR:   w_alu = r_a | r_b;
      OP_XOR:  w_alu = r_a ^ r_b;
      OP_SLL:  w_alu = r_a << w_shamt;
      OP_SRL:  w_alu = r_a >> w_shamt;
      OP_SRA:  w_alu = $signed(r_a) >>> w_shamt;
      OP_SLT:  w_alu = DATA_W'($signed(r_a) < $signed(r_b));
      OP_SLTU: w_alu = DATA_W'(r_a < r_b);
      default: w_alu = '0;
    endcase
  end

  always_comb begin
    w_state_next = r_state;
    case (r_state)
      IDLE:    if (start) w_state_next = EXEC;
      EXEC:    w_state_next = w_mul_start ? MUL : WB;
      MUL:     if (w_mul_done) w_state_next = WB;
      WB:      w_state_next = IDLE;
      default: w_state_next = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) r_state <= IDLE;
    else     r_state <= w_state_next;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_a         <= '0;
      r_b         <= '0;
      r_op        <= '0;
      r_rd        <= '0;
      r_rw        <= '0;
      r_bus_w     <= '0;
      r_reg_write <= 1'b0;
      r_done      <= 1'b0;
      r_zero      <= 1'b0;
      r_err       <= 1'b0;
    end else begin
      // Pulses are high only in the cycle after a write-back load, i.e. in WB.
      r_reg_write <= 1'b0;
      r_done      <= 1'b0;
      r_err       <= 1'b0;
      if (w_accept) begin
        r_a  <= Bus_A;
        r_b  <= use_imm ? {{(DATA_W-16){imm[15]}}, imm} : Bus_B;
        r_op <= op;
        r_rd <= rd;
      end
      if (w_wb_load) begin
        r_rw        <= r_rd;
        r_bus_w     <= w_wb_data;
        r_zero      <= (w_wb_data == '0);
        r_done      <= 1'b1;
        r_reg_write <= w_legal && (r_rd != '0);
        r_err       <= !w_legal;
      end
    end
  end

  assign RW        = r_rw;
  assign Bus_W     = r_bus_w;
  assign reg_write = r_reg_write;
  assign done      = r_done;
  assign zero      = r_zero;
  assign err       = r_err;

endmodule

// File: tb/tb_alu_exec_stage.sv
// Randomised self-checking bench for alu_exec_stage against an arithmetic reference model.
// Define MUL_EN for both bench and RTL to exercise the multiplier.
module tb_alu_exec_stage;

`ifdef MUL_EN
  localparam bit HAS_MUL = 1'b1;
`else
  localparam bit HAS_MUL = 1'b0;
`endif

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        start = 1'b0;
  logic        ready;
  logic [3:0]  op = '0;
  logic [31:0] Bus_A = '0;
  logic [31:0] Bus_B = '0;
  logic        use_imm = 1'b0;
  logic [15:0] imm = '0;
  logic [4:0]  rd = '0;
  logic [4:0]  RW;
  logic [31:0] Bus_W;
  logic        reg_write;
  logic        done;
  logic        zero;
  logic        err;

  int n_checks = 0;
  int n_errors = 0;

  alu_exec_stage dut (
    .clk       (clk),
    .rst       (rst),
    .start     (start),
    .ready     (ready),
    .op        (op),
    .Bus_A     (Bus_A),
    .Bus_B     (Bus_B),
    .use_imm   (use_imm),
    .imm       (imm),
    .rd        (rd),
    .RW        (RW),
    .Bus_W     (Bus_W),
    .reg_write (reg_write),
    .done      (done),
    .zero      (zero),
    .err       (err)
  );

  always #5 clk = ~clk;

  function automatic bit model_legal(input logic [3:0] f_op);
    return (f_op <= 4'd9) || (f_op == 4'd10 && HAS_MUL);
  endfunction

  function automatic logic [31:0] model_result(input logic [3:0] f_op, input logic [31:0] a,
                                               input logic [31:0] b);
    logic [63:0] prod;
    int          sh;
    sh = int'(b[4:0]);
    prod = 64'(a) * 64'(b);
    case (f_op)
      4'd0:    return a + b;
      4'd1:    return a - b;
      4'd2:    return a & b;
      4'd3:    return a | b;
      4'd4:    return a ^ b;
      4'd5:    return a << sh;
      4'd6:    return a >> sh;
      4'd7:    return (a >> sh) | (a[31] ? ~(32'hFFFF_FFFF >> sh) : 32'h0);
      4'd8:    return (int'(a) < int'(b)) ? 32'd1 : 32'd0;
      4'd9:    return (a < b) ? 32'd1 : 32'd0;
      4'd10:   return HAS_MUL ? prod[31:0] : 32'd0;
      default: return 32'd0;
    endcase
  endfunction

  // Issues one instruction from a negedge in IDLE; returns at the negedge after WB.
  task automatic run_op(input logic [3:0] t_op, input logic [31:0] a, input logic [31:0] b,
                        input bit t_imm, input logic [15:0] t_immv, input logic [4:0] t_rd,
                        input string name);
    logic [31:0] b_eff, exp;
    bit          legal, got;
    int          exp_lat, cyc;
    b_eff   = t_imm ? {{16{t_immv[15]}}, t_immv} : b;
    exp     = model_result(t_op, a, b_eff);
    legal   = model_legal(t_op);
    exp_lat = (t_op == 4'd10 && HAS_MUL) ? 34 : 2;
    op = t_op; Bus_A = a; Bus_B = b; use_imm = t_imm; imm = t_immv; rd = t_rd; start = 1'b1;
    n_checks++;
    if (ready !== 1'b1) begin
      n_errors++; $display("FAIL %s ready_before_issue got %b want 1", name, ready);
    end
    @(posedge clk);
    cyc = 0; got = 1'b0;
    while (!got && cyc < 60) begin
      @(negedge clk);
      cyc++;
      if (done === 1'b1) got = 1'b1;
      else begin
        n_checks++;
        if (ready !== 1'b0) begin
          n_errors++; $display("FAIL %s ready_busy cyc %0d got %b want 0", name, cyc, ready);
        end
        start = 1'($urandom); op = 4'($urandom); Bus_A = $urandom; Bus_B = $urandom;
        use_imm = 1'($urandom); imm = 16'($urandom); rd = 5'($urandom);
      end
    end
    start = 1'b0;
    n_checks++;
    if (!got) begin
      n_errors++; $display("FAIL %s done_timeout got none want done at %0d", name, exp_lat);
      return;
    end
    if (cyc !== exp_lat) begin
      n_errors++; $display("FAIL %s latency got %0d want %0d", name, cyc, exp_lat);
    end
    n_checks++;
    if ({RW, Bus_W} !== {t_rd, exp}) begin
      n_errors++; $display("FAIL %s rw/bus_w got %0d/%h want %0d/%h", name, RW, Bus_W, t_rd, exp);
    end
    n_checks++;
    if ({reg_write, err, zero, ready} !== {legal && (t_rd != 0), !legal, exp == 0, 1'b0}) begin
      n_errors++;
      $display("FAIL %s wb_flags{we,err,zero,ready} got %b want %b", name,
               {reg_write, err, zero, ready}, {legal && (t_rd != 0), !legal, exp == 0, 1'b0});
    end
    @(negedge clk);
    n_checks++;
    if ({done, reg_write, err, ready, RW, Bus_W} !== {4'b0001, t_rd, exp}) begin
      n_errors++;
      $display("FAIL %s after_wb{done,we,err,ready} got %b rw %0d bus_w %h want 0001 rw %0d bus_w %h",
               name, {done, reg_write, err, ready}, RW, Bus_W, t_rd, exp);
    end
  endtask

  task automatic test_reset();
    rst = 1'b1; start = 1'b0;
    repeat (3) @(negedge clk);
    n_checks++;
    if ({ready, RW, Bus_W, reg_write, done, zero, err} !== {1'b1, 5'd0, 32'd0, 4'b0000}) begin
      n_errors++;
      $display("FAIL reset_state got ready %b rw %0d bus_w %h we %b done %b zero %b err %b want 1/0/0/0/0/0/0",
               ready, RW, Bus_W, reg_write, done, zero, err);
    end
    rst = 1'b0;
    @(negedge clk);
  endtask

  task automatic test_directed();
    run_op(4'd0, 32'd5, 32'd7, 1'b0, 16'h0, 5'd3, "add");
    run_op(4'd1, 32'd10, 32'd0, 1'b1, 16'hFFFF, 5'd4, "sub_imm");
    run_op(4'd1, 32'd9, 32'd9, 1'b0, 16'h0, 5'd6, "sub_zero");
    run_op(4'd7, 32'h8000_0000, 32'd4, 1'b0, 16'h0, 5'd8, "sra");
    run_op(4'd8, 32'hFFFF_FFFF, 32'd1, 1'b0, 16'h0, 5'd9, "slt");
    run_op(4'd9, 32'hFFFF_FFFF, 32'd1, 1'b0, 16'h0, 5'd10, "sltu");
    run_op(4'd5, 32'h0000_0003, 32'd31, 1'b0, 16'h0, 5'd11, "sll31");
    run_op(4'd12, $urandom, $urandom, 1'b0, 16'h0, 5'd5, "illegal12");
    run_op(4'd10, 32'h0001_0001, 32'h0001_0001, 1'b0, 16'h0, 5'd7, "op10");
    run_op(4'd0, 32'd3, 32'd4, 1'b0, 16'h0, 5'd0, "add_rd0");
  endtask

  task automatic test_random();
    for (int i = 0; i < 40; i++) begin
      run_op(4'($urandom), $urandom, $urandom, 1'($urandom), 16'($urandom), 5'($urandom), "random");
    end
  endtask

  // start held high: each ALU instruction is accepted the cycle the stage is back in IDLE.
  task automatic test_back_to_back();
    logic [31:0] a, b, exp;
    logic [3:0]  t_op;
    logic [4:0]  t_rd;
    int          cyc;
    start = 1'b1; use_imm = 1'b0;
    for (int i = 0; i < 6; i++) begin
      t_op = 4'($urandom_range(0, 9)); a = $urandom; b = $urandom; t_rd = 5'($urandom);
      exp = model_result(t_op, a, b);
      op = t_op; Bus_A = a; Bus_B = b; rd = t_rd;
      cyc = 0;
      do begin
        @(negedge clk);
        cyc++;
      end while (done !== 1'b1 && cyc < 10);
      n_checks++;
      if (cyc !== ((i == 0) ? 2 : 3)) begin
        n_errors++; $display("FAIL b2b_interval #%0d got %0d want %0d", i, cyc, (i == 0) ? 2 : 3);
      end
      n_checks++;
      if ({Bus_W, RW, reg_write} !== {exp, t_rd, t_rd != 0}) begin
        n_errors++;
        $display("FAIL b2b_result #%0d got %h rd %0d we %b want %h rd %0d we %b", i, Bus_W, RW,
                 reg_write, exp, t_rd, t_rd != 0);
      end
    end
    start = 1'b0;
    @(negedge clk);
  endtask

  task automatic test_mid_reset();
    int rst_cyc;
    bit seen;
    run_op(4'd0, 32'd1, 32'd1, 1'b0, 16'h0, 5'd9, "pre_reset");
    rst_cyc = HAS_MUL ? 15 : 1;
    op = HAS_MUL ? 4'd10 : 4'd0; Bus_A = 32'h1234_5678; Bus_B = 32'h0000_00FF;
    use_imm = 1'b0; rd = 5'd12; start = 1'b1;
    @(posedge clk);
    start = 1'b0;
    @(negedge clk);
    repeat (rst_cyc - 1) @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    n_checks++;
    if ({ready, RW, Bus_W, reg_write, done, zero, err} !== {1'b1, 5'd0, 32'd0, 4'b0000}) begin
      n_errors++;
      $display("FAIL mid_reset_state got ready %b rw %0d bus_w %h we %b done %b zero %b err %b want 1/0/0/0/0/0/0",
               ready, RW, Bus_W, reg_write, done, zero, err);
    end
    rst = 1'b0;
    seen = 1'b0;
    repeat (40) begin
      @(negedge clk);
      if (reg_write === 1'b1 || done === 1'b1) seen = 1'b1;
    end
    n_checks++;
    if (seen) begin
      n_errors++; $display("FAIL mid_reset_no_writeback got pulse seen want none");
    end
    run_op(4'd3, 32'hF0F0_0000, 32'h0000_0F0F, 1'b0, 16'h0, 5'd13, "post_reset_or");
  endtask

  initial begin
    test_reset();
    test_directed();
    test_random();
    test_back_to_back();
    test_mid_reset();
    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule
